// File: rtl/decode_stage.sv
// Decode/issue stage: decodes ARM data-processing and LDR/STR (immediate offset)
// into datapath controls held in one output pipeline register.
module decode_stage #(
   parameter int REG_AW = 4,
   parameter int DW     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DW-1:0]     instr,
   output logic              in_ready,
   input  logic              out_ready,
   input  logic              flush,
   output logic              out_valid,
   output logic [3:0]        cond,
   output logic [REG_AW-1:0] A_addr,
   output logic [REG_AW-1:0] B_addr,
   output logic [REG_AW-1:0] shift_addr,
   output logic              sel_shift,
   output logic [1:0]        shift_op,
   output logic [DW-1:0]     shift_imme,
   output logic              sel_A,
   output logic              sel_B,
   output logic [DW-1:0]     imme_data,
   output logic [2:0]        ALU_op,
   output logic              en_status,
   output logic [REG_AW-1:0] w_addr,
   output logic              w_en,
   output logic              is_load,
   output logic              is_store,
   output logic [REG_AW-1:0] st_addr,
   output logic              undef
);

   localparam logic [3:0] OPC_AND = 4'b0000;
   localparam logic [3:0] OPC_EOR = 4'b0001;
   localparam logic [3:0] OPC_SUB = 4'b0010;
   localparam logic [3:0] OPC_ADD = 4'b0100;
   localparam logic [3:0] OPC_TST = 4'b1000;
   localparam logic [3:0] OPC_CMP = 4'b1010;
   localparam logic [3:0] OPC_ORR = 4'b1100;
   localparam logic [3:0] OPC_MOV = 4'b1101;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;

   typedef struct packed {
      logic [3:0]        cond;
      logic [REG_AW-1:0] A_addr;
      logic [REG_AW-1:0] B_addr;
      logic [REG_AW-1:0] shift_addr;
      logic              sel_shift;
      logic [1:0]        shift_op;
      logic [DW-1:0]     shift_imme;
      logic              sel_A;
      logic              sel_B;
      logic [DW-1:0]     imme_data;
      logic [2:0]        ALU_op;
      logic              en_status;
      logic [REG_AW-1:0] w_addr;
      logic              w_en;
      logic              is_load;
      logic              is_store;
      logic [REG_AW-1:0] st_addr;
      logic              undef;
   } ctl_t;

   ctl_t dec;
   ctl_t ctl_q;

   logic            rd_rn, rd_rm, rd_rs, rd_rd;
   logic            dp_sup, dp_mov, dp_wen, dp_stat;
   logic [2:0]      dp_alu;
   logic [DW-1:0]   imm8_ext;
   logic [2*DW-1:0] rot_src;
   logic [2*DW-1:0] rot_out;
   logic            ls_form_ok;
   logic            src_hit;
   logic            hazard;
   logic            advance;

   // ARM rotated immediate: imm8 rotated right by twice the 4-bit rotate field.
   assign imm8_ext = {{(DW-8){1'b0}}, instr[7:0]};
   assign rot_src  = {imm8_ext, imm8_ext};
   assign rot_out  = rot_src >> {instr[11:8], 1'b0};

   assign ls_form_ok = instr[24] && !instr[22] && !instr[21];

   // Data-processing opcode classification.
   always_comb begin
      dp_sup  = 1'b1;
      dp_mov  = 1'b0;
      dp_wen  = 1'b1;
      dp_stat = instr[20];
      dp_alu  = ALU_ADD;
      case (instr[24:21])
         OPC_AND: dp_alu = ALU_AND;
         OPC_EOR: dp_alu = ALU_EOR;
         OPC_SUB: dp_alu = ALU_SUB;
         OPC_ADD: dp_alu = ALU_ADD;
         OPC_ORR: dp_alu = ALU_ORR;
         OPC_TST: begin
            dp_alu  = ALU_AND;
            dp_wen  = 1'b0;
            dp_stat = 1'b1;
         end
         OPC_CMP: begin
            dp_alu  = ALU_SUB;
            dp_wen  = 1'b0;
            dp_stat = 1'b1;
         end
         OPC_MOV: begin
            dp_alu = ALU_ADD;
            dp_mov = 1'b1;
         end
         default: begin
            dp_sup  = 1'b0;
            dp_wen  = 1'b0;
            dp_stat = 1'b0;
         end
      endcase
   end

   // Full decode of the offered word; unsupported encodings leave only cond and undef set.
   always_comb begin
      dec      = '0;
      rd_rn    = 1'b0;
      rd_rm    = 1'b0;
      rd_rs    = 1'b0;
      rd_rd    = 1'b0;
      dec.cond = instr[31:28];
      if (instr[27:26] == 2'b00 && dp_sup) begin
         dec.ALU_op    = dp_alu;
         dec.w_en      = dp_wen;
         dec.en_status = dp_stat;
         dec.w_addr    = instr[15:12];
         if (dp_mov) begin
            dec.sel_A = 1'b1;
         end else begin
            dec.A_addr = instr[19:16];
            rd_rn      = 1'b1;
         end
         if (instr[25]) begin
            dec.sel_B     = 1'b1;
            dec.imme_data = rot_out[DW-1:0];
         end else begin
            dec.B_addr   = instr[3:0];
            dec.shift_op = instr[6:5];
            rd_rm        = 1'b1;
            if (instr[4]) begin
               dec.sel_shift  = 1'b1;
               dec.shift_addr = instr[11:8];
               rd_rs          = 1'b1;
            end else begin
               dec.shift_imme = {{(DW-5){1'b0}}, instr[11:7]};
            end
         end
      end else if (instr[27:25] == 3'b010 && ls_form_ok) begin
         dec.A_addr    = instr[19:16];
         dec.sel_B     = 1'b1;
         dec.imme_data = {{(DW-12){1'b0}}, instr[11:0]};
         dec.ALU_op    = instr[23] ? ALU_ADD : ALU_SUB;
         rd_rn         = 1'b1;
         if (instr[20]) begin
            dec.is_load = 1'b1;
            dec.w_en    = 1'b1;
            dec.w_addr  = instr[15:12];
         end else begin
            dec.is_store = 1'b1;
            dec.st_addr  = instr[15:12];
            rd_rd        = 1'b1;
         end
      end else begin
         dec.undef = 1'b1;
      end
   end

   // A load leaving this cycle cannot forward to a reader right behind it: hold that reader one cycle.
   assign src_hit = (rd_rn && dec.A_addr     == ctl_q.w_addr) ||
                    (rd_rm && dec.B_addr     == ctl_q.w_addr) ||
                    (rd_rs && dec.shift_addr == ctl_q.w_addr) ||
                    (rd_rd && dec.st_addr    == ctl_q.w_addr);
   assign hazard   = out_valid && ctl_q.is_load && out_ready && in_valid && src_hit;
   assign advance  = !out_valid || out_ready;
   assign in_ready = !rst && advance && !hazard && !flush;

   // Output pipeline register; a bubble clears every control so nothing stale reaches the datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         ctl_q     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         ctl_q     <= '0;
      end else if (advance) begin
         if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            ctl_q     <= dec;
         end else begin
            out_valid <= 1'b0;
            ctl_q     <= '0;
         end
      end
   end

   assign cond       = ctl_q.cond;
   assign A_addr     = ctl_q.A_addr;
   assign B_addr     = ctl_q.B_addr;
   assign shift_addr = ctl_q.shift_addr;
   assign sel_shift  = ctl_q.sel_shift;
   assign shift_op   = ctl_q.shift_op;
   assign shift_imme = ctl_q.shift_imme;
   assign sel_A      = ctl_q.sel_A;
   assign sel_B      = ctl_q.sel_B;
   assign imme_data  = ctl_q.imme_data;
   assign ALU_op     = ctl_q.ALU_op;
   assign en_status  = ctl_q.en_status;
   assign w_addr     = ctl_q.w_addr;
   assign w_en       = ctl_q.w_en;
   assign is_load    = ctl_q.is_load;
   assign is_store   = ctl_q.is_store;
   assign st_addr    = ctl_q.st_addr;
   assign undef      = ctl_q.undef;

endmodule
